// File: rtl/controlpack.sv
// Shared types and constants for the register dump read-out path.
package controlpack;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StLoad,
        StStartBit,
        StDataBits,
        StStopBit,
        StFinish
    } dump_state_e;

    localparam logic DUMP_IDLE_LEVEL = 1'b1;

    localparam int unsigned REG_SEL_W = 2;

    typedef enum logic [REG_SEL_W-1:0] {
        RegSel0,
        RegSel1,
        RegSel2,
        RegSel3
    } register_sel_e;

endpackage

// File: rtl/serial_byte_tx.sv
// UART-style frame transmitter: start bit, LSB-first data bits, stop bit.
module serial_byte_tx
    import controlpack::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = 8,
    parameter int unsigned CLKS_PER_BIT   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic [DATA_BUS_WIDTH-1:0] data_in,
    output logic                      tx,
    output logic                      frame_done,
    output dump_state_e               phase_next
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (DATA_BUS_WIDTH > 1) ? $clog2(DATA_BUS_WIDTH) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BUS_WIDTH - 1);

    dump_state_e               phase_q, phase_d;
    logic [BaudW-1:0]          baud_q, baud_d;
    logic [BitW-1:0]           bit_q, bit_d;
    logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      baud_wrap;

    assign baud_wrap = (baud_q == BaudLast);

    always_comb begin
        phase_d    = phase_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        frame_done = 1'b0;
        if (phase_q != StIdle) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end
        // tx_d is the level of the bit about to start, so tx stays a pure register.
        case (phase_q)
            StIdle: begin
                tx_d = DUMP_IDLE_LEVEL;
                if (load) begin
                    shift_d = data_in;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    phase_d = StStartBit;
                end
            end
            StStartBit: begin
                if (baud_wrap) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    phase_d = StDataBits;
                end
            end
            StDataBits: begin
                if (baud_wrap) begin
                    if (bit_q == BitLast) begin
                        tx_d    = DUMP_IDLE_LEVEL;
                        phase_d = StStopBit;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            StStopBit: begin
                if (baud_wrap) begin
                    frame_done = 1'b1;
                    phase_d    = StIdle;
                end
            end
            default: begin
                tx_d    = DUMP_IDLE_LEVEL;
                phase_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= DUMP_IDLE_LEVEL;
        end else begin
            phase_q <= phase_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign phase_next = phase_d;

endmodule

// File: rtl/reg_dump_tx.sv
// Walks every register through one read select and ships each value as a serial frame.
module reg_dump_tx
    import controlpack::*;
#(
    parameter int unsigned DATA_BUS_WIDTH = 8,
    parameter int unsigned CLKS_PER_BIT   = 4,
    parameter int unsigned NUM_REGS       = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      dump_start,
    output register_sel_e             reg_sel,
    input  logic [DATA_BUS_WIDTH-1:0] reg_data,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam logic [REG_SEL_W-1:0] LastIdx = REG_SEL_W'(NUM_REGS - 1);

    dump_state_e          state_q, state_d;
    logic [REG_SEL_W-1:0] idx_q, idx_d;
    register_sel_e        reg_sel_q, reg_sel_d;
    logic                 load;
    logic                 frame_done;
    dump_state_e          ser_phase_next;

    serial_byte_tx #(
        .DATA_BUS_WIDTH(DATA_BUS_WIDTH),
        .CLKS_PER_BIT  (CLKS_PER_BIT)
    ) u_serial (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .data_in   (reg_data),
        .tx        (tx),
        .frame_done(frame_done),
        .phase_next(ser_phase_next)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        reg_sel_d = reg_sel_q;
        load      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dump_start) begin
                    idx_d   = '0;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                reg_sel_d = register_sel_e'(idx_q);
                state_d   = StLoad;
            end
            StLoad: begin
                // Read data is combinational, so it is valid now for the selected index.
                load    = 1'b1;
                state_d = StStartBit;
            end
            StStartBit, StDataBits, StStopBit: begin
                if (frame_done) begin
                    if (idx_q == LastIdx) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StSelect;
                    end
                end else begin
                    state_d = ser_phase_next;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            reg_sel_q <= RegSel0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            reg_sel_q <= reg_sel_d;
        end
    end

    assign reg_sel = reg_sel_q;
    assign busy    = (state_q != StIdle) && (state_q != StFinish);
    assign done    = (state_q == StFinish);

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: a 4-clk/bit and a 1-clk/bit instance checked against a timeline model.
module tb_reg_dump_tx;
    import controlpack::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    regs   [2][4];
    logic          start  [2];
    logic          tx_w   [2];
    logic          busy_w [2];
    logic          done_w [2];
    register_sel_e sel_w  [2];
    logic [7:0]    rdata  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int C = (g == 0) ? 4 : 1;
        localparam int P = 2 + 10 * C;

        int         cur;
        logic [7:0] snap [4];
        logic [8:0] rx_buf [64];
        int         rx_n = 0;

        assign rdata[g] = regs[g][sel_w[g]];

        reg_dump_tx #(
            .DATA_BUS_WIDTH(8),
            .CLKS_PER_BIT  (C),
            .NUM_REGS      (4)
        ) u_dut (
            .clock     (clk),
            .reset     (rst),
            .dump_start(start[g]),
            .reg_sel   (sel_w[g]),
            .reg_data  (rdata[g]),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g])
        );

        // cur = cycles since the start-accept edge (0 when idle); 4*P+1 is the done cycle.
        always @(posedge clk or posedge rst) begin : model
            logic [1:0] ki;
            if (rst) begin
                cur <= 0;
            end else begin
                ki = 2'((cur - 1) / P);
                if (cur >= 1 && cur <= 4 * P && (cur - 1) % P == 1) snap[ki] <= regs[g][ki];
                if (cur == 0) cur <= start[g] ? 1 : 0;
                else if (cur == 4 * P + 1) cur <= 0;
                else cur <= cur + 1;
            end
        end

        always @(negedge clk) begin : cmp
            logic       etx, ebusy, edone;
            int         o, b;
            logic [1:0] k;
            etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
            if (cur == 4 * P + 1) begin
                edone = 1'b1;
            end else if (cur != 0) begin
                ebusy = 1'b1;
                k = 2'((cur - 1) / P);
                o = (cur - 1) % P;
                if (o >= 2) begin
                    b = (o - 2) / C;
                    if (b == 0) etx = 1'b0;
                    else if (b < 9) etx = snap[k][3'(b - 1)];
                end
                if (o == 1) chk($sformatf("g%0d reg_sel t=%0d", g, cur), sel_w[g], k);
            end
            chk($sformatf("g%0d tx t=%0d", g, cur), tx_w[g], etx);
            chk($sformatf("g%0d busy t=%0d", g, cur), busy_w[g], ebusy);
            chk($sformatf("g%0d done t=%0d", g, cur), done_w[g], edone);
        end

        // Independent line receiver: samples mid-bit, stores {stop, data}.
        always begin : rx
            logic [8:0] v;
            @(negedge clk);
            if (!rst && tx_w[g] === 1'b0) begin
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    v[i] = tx_w[g];
                end
                repeat (C) @(negedge clk);
                v[8] = tx_w[g];
                rx_buf[rx_n % 64] = v;
                rx_n = rx_n + 1;
            end
        end
    end

    function automatic int rx_count(input int g);
        return (g == 0) ? g_inst[0].rx_n : g_inst[1].rx_n;
    endfunction

    function automatic logic [8:0] rx_at(input int g, input int i);
        return (g == 0) ? g_inst[0].rx_buf[i % 64] : g_inst[1].rx_buf[i % 64];
    endfunction

    task automatic set_regs(input int g, input logic [7:0] a, b, c, d);
        regs[g][0] = a; regs[g][1] = b; regs[g][2] = c; regs[g][3] = d;
    endtask

    task automatic chk_frames(input int g, input int base, input logic [7:0] a, b, c, d);
        logic [7:0] e [4];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        chk($sformatf("g%0d frame count", g), rx_count(g) - base, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("g%0d frame %0d", g, i), rx_at(g, base + i), {1'b1, e[i]});
    endtask

    task automatic run_dump(input int g, input int lim, output int lat, output int bcnt);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        lat  = 1;
        bcnt = busy_w[g] ? 1 : 0;
        while (done_w[g] !== 1'b1 && lat < lim) begin
            @(negedge clk);
            lat++;
            if (busy_w[g]) bcnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, bc, base, dn, idl;
        set_regs(0, 8'hA5, 8'h3C, 8'h00, 8'hFF);
        set_regs(1, 8'h80, 8'h01, 8'h55, 8'hAA);
        start[0] = 1'b0;
        start[1] = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d reset tx", g), tx_w[g], 1);
            chk($sformatf("g%0d reset busy", g), busy_w[g], 0);
            chk($sformatf("g%0d reset done", g), done_w[g], 0);
            chk($sformatf("g%0d reset reg_sel", g), sel_w[g], 0);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        // Plain dump with default timing.
        base = rx_count(0);
        run_dump(0, 400, lat, bc);
        chk("dump latency", lat, 169);
        chk("busy cycles", bc, 168);
        chk_frames(0, base, 8'hA5, 8'h3C, 8'h00, 8'hFF);
        repeat (5) @(negedge clk);

        // Writes during the dump plus a start request while busy.
        base = rx_count(0);
        fork
            run_dump(0, 400, lat, bc);
            begin
                repeat (10) @(negedge clk);
                regs[0][3] = 8'h77;
                repeat (40) @(negedge clk);
                regs[0][0] = 8'h11;
                start[0] = 1'b1;
                @(negedge clk);
                start[0] = 1'b0;
            end
        join
        chk("write-during latency", lat, 169);
        chk_frames(0, base, 8'hA5, 8'h3C, 8'h00, 8'h77);
        dn = 0;
        repeat (200) begin
            @(negedge clk);
            if (done_w[0]) dn++;
        end
        chk("no extra done", dn, 0);

        // Asynchronous reset in the middle of reg1's data bits.
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (54) @(negedge clk);
        chk("tx before reset", tx_w[0], 0);
        #2 rst = 1'b1;
        #1;
        chk("tx in reset", tx_w[0], 1);
        chk("busy in reset", busy_w[0], 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk);
        base = rx_count(0);
        run_dump(0, 400, lat, bc);
        chk("post-reset latency", lat, 169);
        chk_frames(0, base, 8'h11, 8'h3C, 8'h00, 8'h77);

        // Random register writes and start pulses on both instances.
        repeat (1500) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if ($urandom_range(0, 7) == 0) regs[g][$urandom_range(0, 3)] = 8'($urandom);
                start[g] = ($urandom_range(0, 24) == 0);
            end
        end
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (200) @(negedge clk);

        // dump_start held high: back-to-back dumps with one idle cycle between.
        start[0] = 1'b1;
        dn  = 0;
        idl = 0;
        repeat (400) begin
            @(negedge clk);
            if (done_w[0]) dn++;
            if (!busy_w[0] && !done_w[0]) idl++;
        end
        start[0] = 1'b0;
        chk("held start done count", dn, 2);
        chk("held start idle gaps", idl, 2);
        repeat (200) @(negedge clk);

        // One clock per bit.
        set_regs(1, 8'h80, 8'h01, 8'h55, 8'hAA);
        base = rx_count(1);
        run_dump(1, 200, lat, bc);
        chk("cpb1 latency", lat, 49);
        chk("cpb1 busy cycles", bc, 48);
        chk_frames(1, base, 8'h80, 8'h01, 8'h55, 8'hAA);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_tx.md
Name: reg_dump_tx

Overview:
- Debug read-out engine and read-side counterpart to the register file write path.
- On a start request it walks register indices 0..NUM_REGS-1 through one register-file read-select port.
- It captures each value and transmits it as a UART-style serial frame on a single wire.
- Sits beside the register file, drives one of its read selects (reg_2_out_sel), and feeds a debug pin.

Parameters:
- DATA_BUS_WIDTH, 8, width of each register and of each serial data field
- CLKS_PER_BIT, 4, clock cycles per serial bit (legal range ≥1)
- NUM_REGS, 4, number of registers dumped; must match the register_sel_e range

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- dump_start  input  1  request pulse; sampled only in IDLE
- reg_sel  output  register_sel_e  read select driven to the register file
- reg_data  input  DATA_BUS_WIDTH  combinational read data for reg_sel
- tx  output  1  serial line; idle high
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the last frame's stop bit completes

Behaviour:
- Reset (asynchronous, immediate): tx=1, busy=0, done=0, reg_sel=index 0, state=IDLE, bit/baud/index counters=0.
- Reset mid-frame aborts the dump; it is never resumed.
- States: IDLE, SELECT, LOAD, START_BIT, DATA_BITS, STOP_BIT, FINISH.
- IDLE: tx=1. dump_start=1 -> SELECT, index=0, busy=1 from the next cycle.
- SELECT: reg_sel=index (registered). Next cycle -> LOAD.
- LOAD: shift register <= reg_data; the register file read is combinational, so this is valid in the same cycle. -> START_BIT.
- START_BIT: tx=0 for CLKS_PER_BIT cycles.
- DATA_BITS: DATA_BUS_WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles.
- Leaving STOP_BIT:
  - index==NUM_REGS-1 -> FINISH.
  - Otherwise index+1 -> SELECT.
- FINISH: done=1 and busy=0 in this single cycle; next cycle -> IDLE.
- Per-register cost: 2 + (DATA_BUS_WIDTH+2)*CLKS_PER_BIT cycles. With defaults that is 42 per register and 168 plus 1 (FINISH) for a full dump.
- Snapshot semantics: each register is sampled at its own LOAD. A register write during the dump is visible only for registers not yet loaded; it does not corrupt an in-flight frame.
- dump_start while busy (including the FINISH cycle) is ignored, not queued.
- dump_start held high continuously: a new dump begins in the first IDLE cycle after FINISH.
- tx is a registered output; no combinational path from any input to tx.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter advances only on the baud wrap.
- CLKS_PER_BIT=1 must work (one cycle per bit).

Decomposition:
- Shared package (controlpack):
  - dump_state_e enum (the seven states above).
  - DUMP_IDLE_LEVEL constant (1'b1).
  - register_sel_e, reused for reg_sel.
- One natural sub-module, serial_byte_tx:
  - Baud counter, shift register, start/data/stop sequencing.
  - Handshake: load/data_in in, tx/frame_done out.
  - reg_dump_tx keeps the index walk and the SELECT/LOAD/FINISH control.

Test Plan:
- Reset values: registers = {0xA5, 0x3C, 0x00, 0xFF}, defaults, pulse dump_start -> reg_sel steps 0,1,2,3. tx decodes to 0xA5, 0x3C, 0x00, 0xFF (LSB first, start 0, stop 1, 4 clk/bit). done pulses once exactly 169 cycles after the start-accept edge; busy is high for the 168 cycles before it.
- Write during dump: reg3 written 0x77 during reg0's data bits -> fourth frame carries 0x77. Reg0 is written 0x11 during reg1's frame -> dump still shows the original reg0 value.
- Start while busy: second dump_start pulse at cycle 50 -> no extra frames; exactly one done pulse.
- Async reset mid-dump: reset asserted in reg1's DATA_BITS -> tx=1, busy=0 immediately without a clock edge. After release, tx stays high until a new dump_start, and the new dump begins at reg0.
- CLKS_PER_BIT=1 build: registers {0x80, 0x01, 0x55, 0xAA} -> each bit lasts one cycle, frames decode correctly, done fires 2+10 = 12 cycles per register after start (48 total + 1).
- dump_start held high for 400 cycles -> back-to-back dumps separated by exactly one IDLE cycle; tx remains high in that gap.
